// File: rtl/life_pkg.sv
// Shared state encoding and map constants for the Game-of-Life generation scheduler.
package life_pkg;

    localparam int MAP_DIM = 32;
    localparam int CELL_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_EVAL  = 2'd2,
        ST_SWAP  = 2'd3
    } state_t;

endpackage

// File: rtl/life_ram_arbiter.sv
// Single-port map RAM mux: the evaluator owns the RAM while a pass runs, otherwise edit beats display.
module life_ram_arbiter
    import life_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  state_t            state,
    input  logic              bank,
    input  logic [ADDR_W-1:0] eval_addr,
    input  logic              eval_we,
    input  logic [CELL_W-1:0] eval_wdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              edit_req,
    input  logic [ADDR_W-1:0] edit_addr,
    input  logic [CELL_W-1:0] edit_wdata,
    output logic [ADDR_W:0]   ram_addr,
    output logic              ram_we,
    output logic [CELL_W-1:0] ram_wdata,
    output logic              disp_gnt,
    output logic              edit_gnt
);

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        disp_gnt  = 1'b0;
        edit_gnt  = 1'b0;
        if (state == ST_START || state == ST_EVAL) begin
            // evaluator reads the front bank and writes the back bank
            ram_addr = {(eval_we ? ~bank : bank), eval_addr};
            ram_we   = eval_we;
            if (eval_we) ram_wdata = eval_wdata;
        end else if (edit_req) begin
            edit_gnt  = 1'b1;
            ram_addr  = {bank, edit_addr};
            ram_we    = 1'b1;
            ram_wdata = edit_wdata;
        end else if (disp_req) begin
            disp_gnt = 1'b1;
            ram_addr = {bank, disp_addr};
        end
    end

endmodule

// File: rtl/life_gen_scheduler.sv
// Game-of-Life generation sequencer: run/step scheduling, evaluation watchdog and ping-pong bank swap.
module life_gen_scheduler
    import life_pkg::*;
#(
    parameter int ADDR_W   = 2 * $clog2(MAP_DIM),
    parameter int PERIOD_W = 24,
    parameter int WD_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                step,
    input  logic [PERIOD_W-1:0] period,
    output logic                eval_start,
    input  logic                eval_done,
    input  logic [ADDR_W-1:0]   eval_addr,
    input  logic                eval_we,
    input  logic [CELL_W-1:0]   eval_wdata,
    output logic [CELL_W-1:0]   eval_rdata,
    input  logic                disp_req,
    input  logic [ADDR_W-1:0]   disp_addr,
    output logic                disp_gnt,
    output logic                disp_valid,
    output logic [CELL_W-1:0]   disp_rdata,
    input  logic                edit_req,
    input  logic [ADDR_W-1:0]   edit_addr,
    input  logic [CELL_W-1:0]   edit_wdata,
    output logic                edit_gnt,
    output logic [ADDR_W:0]     ram_addr,
    output logic                ram_we,
    output logic [CELL_W-1:0]   ram_wdata,
    input  logic [CELL_W-1:0]   ram_rdata,
    output logic                bank,
    output logic [15:0]         gen_count,
    output logic                busy,
    output logic                wd_error
);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] timer_q, timer_d, period_m1;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [15:0]         gen_count_q, gen_count_d;
    logic                pending_q, pending_d;
    logic                bank_q, bank_d;
    logic                wd_error_q, wd_error_d;
    logic                disp_valid_q, disp_valid_d;
    logic                start_go, wd_expire;

    assign period_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign start_go  = (state_q == ST_IDLE) && (pending_q || (run && timer_q >= period_m1));
    assign wd_expire = (state_q == ST_EVAL) && !eval_done && (wd_q == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_go) state_d = ST_START;
            ST_START: state_d = ST_EVAL;
            ST_EVAL: begin
                if (eval_done)      state_d = ST_SWAP;
                else if (wd_expire) state_d = ST_IDLE;
            end
            ST_SWAP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        eval_start = (state_q == ST_START);
        busy       = (state_q != ST_IDLE);
    end

    // Timer, pending and watchdog are cleared on entry to START so run-mode starts land exactly `period` apart.
    always_comb begin
        timer_d = '0;
        if (!start_go && run) timer_d = (timer_q == '1) ? timer_q : timer_q + PERIOD_W'(1);
        pending_d = start_go ? 1'b0 : (pending_q | step);
        wd_d = wd_q;
        if (state_q == ST_START)                  wd_d = '0;
        else if (state_q == ST_EVAL && wd_q != '1) wd_d = wd_q + WD_W'(1);
        wd_error_d = wd_expire ? 1'b1 : (step ? 1'b0 : wd_error_q);
        bank_d      = (state_q == ST_SWAP) ? ~bank_q : bank_q;
        gen_count_d = (state_q == ST_SWAP) ? gen_count_q + 16'd1 : gen_count_q;
        disp_valid_d = disp_gnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q      <= '0;
            wd_q         <= '0;
            gen_count_q  <= '0;
            pending_q    <= 1'b0;
            bank_q       <= 1'b0;
            wd_error_q   <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            wd_q         <= wd_d;
            gen_count_q  <= gen_count_d;
            pending_q    <= pending_d;
            bank_q       <= bank_d;
            wd_error_q   <= wd_error_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    life_ram_arbiter #(.ADDR_W(ADDR_W)) u_arb (
        .state      (state_q),
        .bank       (bank_q),
        .eval_addr  (eval_addr),
        .eval_we    (eval_we),
        .eval_wdata (eval_wdata),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .edit_req   (edit_req),
        .edit_addr  (edit_addr),
        .edit_wdata (edit_wdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .disp_gnt   (disp_gnt),
        .edit_gnt   (edit_gnt)
    );

    assign bank       = bank_q;
    assign gen_count  = gen_count_q;
    assign wd_error   = wd_error_q;
    assign disp_valid = disp_valid_q;
    assign eval_rdata = ram_rdata;
    assign disp_rdata = ram_rdata;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Scenario bench for life_gen_scheduler with a behavioural evaluator, map RAM and generation model.
`timescale 1ns/1ps
module tb_life_gen_scheduler;

    logic        clk = 1'b0, reset = 1'b1, run = 1'b0, step = 1'b0;
    logic [23:0] period = '0;
    logic        eval_start, eval_done = 1'b0, eval_we = 1'b0;
    logic [9:0]  eval_addr = '0, disp_addr = '0, edit_addr = '0;
    logic [7:0]  eval_wdata = '0, eval_rdata, disp_rdata, edit_wdata = '0, ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic        disp_req = 1'b0, disp_gnt, disp_valid, edit_req = 1'b0, edit_gnt;
    logic [10:0] ram_addr;
    logic        ram_we, bank, busy, wd_error;
    logic [15:0] gen_count;

    int   n_checks = 0, n_fail = 0;
    int   cyc = 0, n_starts = 0, epoch = 0;
    int   eval_lat = 1200;
    bit   eval_hang = 1'b0;
    int   exp_gen = 0;
    logic exp_bank = 1'b0;
    logic [7:0] mem [0:2047];

    life_gen_scheduler dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .period(period),
        .eval_start(eval_start), .eval_done(eval_done), .eval_addr(eval_addr),
        .eval_we(eval_we), .eval_wdata(eval_wdata), .eval_rdata(eval_rdata),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_valid(disp_valid), .disp_rdata(disp_rdata),
        .edit_req(edit_req), .edit_addr(edit_addr), .edit_wdata(edit_wdata), .edit_gnt(edit_gnt),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .bank(bank), .gen_count(gen_count), .busy(busy), .wd_error(wd_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) if (eval_start === 1'b1) n_starts++;

    // Evaluator: registers eval_start, then needs eval_lat cycles, so done lands eval_lat+1 cycles after it.
    initial begin : eval_model
        int e;
        forever begin
            @(negedge clk);
            if (eval_start === 1'b1 && !eval_hang) begin
                e = epoch;
                for (int k = 0; k <= eval_lat; k++) begin
                    @(posedge clk);
                    if (epoch != e) break;
                end
                if (epoch == e) begin
                    #1 eval_done = 1'b1;
                    @(posedge clk);
                    #1 eval_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        epoch++;
        tick();
        tick();
        reset = 1'b0;
        exp_gen  = 0;
        exp_bank = 1'b0;
    endtask

    task automatic pulse_step();
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic wait_start(input int budget, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (eval_start !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (eval_start !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_start: eval_start=%b after %0d cycles, required 1", tag, eval_start, budget);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag, output int nbusy);
        nbusy = 0;
        while (busy === 1'b1 && nbusy < budget) begin
            nbusy++;
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", tag, busy, budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({eval_start, disp_gnt, edit_gnt, disp_valid, ram_we, bank, busy, wd_error, gen_count, ram_addr, ram_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: start=%b dg=%b eg=%b dv=%b we=%b bank=%b busy=%b wd=%b gen=%0d addr=%h wd=%h, required all 0",
                     eval_start, disp_gnt, edit_gnt, disp_valid, ram_we, bank, busy, wd_error, gen_count, ram_addr, ram_wdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_step();
        int base, nb;
        base = n_starts;
        eval_lat = 1200;
        pulse_step();
        wait_start(20, "single");
        wait_idle(5000, "single", nb);
        exp_gen++;
        exp_bank = ~exp_bank;
        repeat (20) @(negedge clk);
        n_checks++;
        if (nb != 1203) begin n_fail++; $display("FAIL single_busy_len: got %0d cycles, required 1203", nb); end
        n_checks++;
        if (n_starts - base != 1) begin n_fail++; $display("FAIL single_start_cnt: got %0d, required 1", n_starts - base); end
        n_checks++;
        if (bank !== exp_bank || gen_count !== 16'(exp_gen)) begin
            n_fail++;
            $display("FAIL single_gen: bank=%b gen=%0d, required bank=%b gen=%0d", bank, gen_count, exp_bank, exp_gen);
        end
    endtask

    task automatic test_edit_disp();
        logic [9:0] a, pa, da;
        logic [7:0] d, pd, ed;
        pa = '0;
        pd = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            a = 10'($urandom);
            d = 8'($urandom);
            da = (i % 2 == 0) ? a : pa;
            ed = (da == a) ? d : pd;
            edit_req = 1'b1; edit_addr = a; edit_wdata = d;
            disp_req = 1'b1; disp_addr = da;
            @(negedge clk);
            n_checks++;
            if (edit_gnt !== 1'b1 || disp_gnt !== 1'b0 || ram_we !== 1'b1 || ram_addr !== {exp_bank, a} || ram_wdata !== d) begin
                n_fail++;
                $display("FAIL edit_prio: eg=%b dg=%b we=%b addr=%h data=%h, required eg=1 dg=0 we=1 addr=%h data=%h",
                         edit_gnt, disp_gnt, ram_we, ram_addr, ram_wdata, {exp_bank, a}, d);
            end
            tick();
            edit_req = 1'b0;
            @(negedge clk);
            n_checks++;
            if (disp_gnt !== 1'b1 || edit_gnt !== 1'b0 || ram_we !== 1'b0 || ram_addr !== {exp_bank, da} || disp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL disp_grant: dg=%b eg=%b we=%b addr=%h dv=%b, required dg=1 eg=0 we=0 addr=%h dv=0",
                         disp_gnt, edit_gnt, ram_we, ram_addr, disp_valid, {exp_bank, da});
            end
            tick();
            disp_req = 1'b0;
            @(negedge clk);
            n_checks++;
            if (disp_valid !== 1'b1 || disp_rdata !== ed) begin
                n_fail++;
                $display("FAIL disp_read: dv=%b data=%h, required dv=1 data=%h", disp_valid, disp_rdata, ed);
            end
            pa = a;
            pd = d;
        end
    endtask

    task automatic test_eval_arb();
        logic [9:0] da;
        do_reset();
        eval_lat = 20;
        da = 10'($urandom);
        tick();
        disp_req = 1'b1;
        disp_addr = da;
        pulse_step();
        wait_start(20, "arb");
        n_checks++;
        if (disp_gnt !== 1'b0 || ram_we !== 1'b0 || ram_addr !== {exp_bank, 10'h000}) begin
            n_fail++;
            $display("FAIL arb_start_cycle: dg=%b we=%b addr=%h, required dg=0 we=0 addr=%h", disp_gnt, ram_we, ram_addr, {exp_bank, 10'h000});
        end
        for (int k = 1; k <= eval_lat + 1; k++) begin
            tick();
            if (k == 1) begin
                eval_we = 1'b1; eval_addr = 10'h021;
            end else begin
                eval_we = 1'($urandom); eval_addr = 10'($urandom);
            end
            eval_wdata = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if (disp_gnt !== 1'b0 || edit_gnt !== 1'b0 || busy !== 1'b1 || ram_we !== eval_we ||
                ram_addr !== {(eval_we ? ~exp_bank : exp_bank), eval_addr} || (eval_we && ram_wdata !== eval_wdata)) begin
                n_fail++;
                $display("FAIL arb_eval_k%0d: dg=%b busy=%b we=%b addr=%h data=%h, required dg=0 busy=1 we=%b addr=%h data=%h",
                         k, disp_gnt, busy, ram_we, ram_addr, ram_wdata, eval_we,
                         {(eval_we ? ~exp_bank : exp_bank), eval_addr}, eval_wdata);
            end
            if (k == 1) begin
                n_checks++;
                if (ram_addr !== 11'h421 || ram_we !== 1'b1) begin
                    n_fail++;
                    $display("FAIL arb_back_bank: addr=%h we=%b, required addr=421 we=1", ram_addr, ram_we);
                end
            end
        end
        tick();
        eval_we = 1'b0;
        eval_addr = '0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || disp_gnt !== 1'b1 || ram_addr !== {exp_bank, da} || bank !== exp_bank) begin
            n_fail++;
            $display("FAIL arb_swap_cycle: busy=%b dg=%b addr=%h bank=%b, required busy=1 dg=1 addr=%h bank=%b",
                     busy, disp_gnt, ram_addr, bank, {exp_bank, da}, exp_bank);
        end
        exp_gen++;
        exp_bank = ~exp_bank;
        tick();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || bank !== exp_bank || disp_gnt !== 1'b1 || ram_addr !== {exp_bank, da} ||
            disp_valid !== 1'b1 || gen_count !== 16'(exp_gen)) begin
            n_fail++;
            $display("FAIL arb_after_swap: busy=%b bank=%b dg=%b addr=%h dv=%b gen=%0d, required busy=0 bank=%b dg=1 addr=%h dv=1 gen=%0d",
                     busy, bank, disp_gnt, ram_addr, disp_valid, gen_count, exp_bank, {exp_bank, da}, exp_gen);
        end
        tick();
        disp_req = 1'b0;
    endtask

    // Run mode: first start lands `period` cycles after run rises; later starts are max(period, lat+4) apart
    // since a generation occupies lat+3 busy cycles plus one idle decision cycle.
    task automatic run_three(input int p, input int lat, input string tag);
        int r, t_prev, pe, gap, nb;
        eval_lat = lat;
        period = 24'(p);
        pe = (p == 0) ? 1 : p;
        gap = (pe > lat + 4) ? pe : lat + 4;
        tick();
        run = 1'b1;
        r = cyc;
        t_prev = r;
        for (int g = 0; g < 3; g++) begin
            wait_start(pe + lat + 20, tag);
            n_checks++;
            if (cyc - t_prev != ((g == 0) ? pe : gap)) begin
                n_fail++;
                $display("FAIL %s_spacing_g%0d: got %0d cycles, required %0d", tag, g, cyc - t_prev, (g == 0) ? pe : gap);
            end
            t_prev = cyc;
        end
        tick();
        run = 1'b0;
        wait_idle(lat + 20, tag, nb);
        exp_gen += 3;
        exp_bank = ~exp_bank;
        n_checks++;
        if (gen_count !== 16'(exp_gen) || bank !== exp_bank) begin
            n_fail++;
            $display("FAIL %s_gen: gen=%0d bank=%b, required gen=%0d bank=%b", tag, gen_count, bank, exp_gen, exp_bank);
        end
    endtask

    task automatic test_run_period();
        do_reset();
        run_three(5000, 1200, "run5000");
    endtask

    task automatic test_run_random();
        int lat, p, sel;
        for (int i = 0; i < 4; i++) begin
            lat = $urandom_range(30, 3);
            sel = $urandom_range(3, 0);
            p = (i == 0) ? 0 : (sel == 0) ? 1 : $urandom_range(2 * lat + 10, 1);
            run_three(p, lat, "runrnd");
        end
    endtask

    task automatic test_step_with_run();
        int base, p;
        p = 50;
        base = n_starts;
        eval_lat = 10;
        period = 24'(p);
        repeat (3) tick();
        run = 1'b1;
        repeat (p - 1) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        @(negedge clk);
        n_checks++;
        if (eval_start !== 1'b1) begin n_fail++; $display("FAIL steprun_start: eval_start=%b, required 1", eval_start); end
        tick();
        run = 1'b0;
        repeat (100) tick();
        exp_gen++;
        exp_bank = ~exp_bank;
        n_checks++;
        if (n_starts - base != 1 || gen_count !== 16'(exp_gen)) begin
            n_fail++;
            $display("FAIL steprun_single: starts=%0d gen=%0d, required starts=1 gen=%0d", n_starts - base, gen_count, exp_gen);
        end
    endtask

    task automatic test_watchdog();
        int nb;
        eval_hang = 1'b1;
        pulse_step();
        wait_start(20, "wd");
        wait_idle(70000, "wd", nb);
        n_checks++;
        if (nb != 65537 || wd_error !== 1'b1 || bank !== exp_bank || gen_count !== 16'(exp_gen)) begin
            n_fail++;
            $display("FAIL wd_expire: busy_len=%0d wd=%b bank=%b gen=%0d, required busy_len=65537 wd=1 bank=%b gen=%0d",
                     nb, wd_error, bank, gen_count, exp_bank, exp_gen);
        end
        eval_hang = 1'b0;
        eval_lat = 10;
        pulse_step();
        @(negedge clk);
        n_checks++;
        if (wd_error !== 1'b0) begin n_fail++; $display("FAIL wd_clear: wd_error=%b, required 0", wd_error); end
        wait_start(20, "wd_next");
        wait_idle(100, "wd_next", nb);
        exp_gen++;
        exp_bank = ~exp_bank;
        n_checks++;
        if (gen_count !== 16'(exp_gen) || bank !== exp_bank) begin
            n_fail++;
            $display("FAIL wd_next_gen: gen=%0d bank=%b, required gen=%0d bank=%b", gen_count, bank, exp_gen, exp_bank);
        end
    endtask

    task automatic test_reset_mid_eval();
        int base;
        eval_lat = 100;
        pulse_step();
        wait_start(20, "rst");
        repeat (5) tick();
        reset = 1'b1;
        epoch++;
        #1;
        n_checks++;
        if ({eval_start, disp_gnt, edit_gnt, disp_valid, ram_we, bank, busy, wd_error, gen_count, ram_addr} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_eval: start=%b busy=%b bank=%b gen=%0d dv=%b we=%b addr=%h, required all 0",
                     eval_start, busy, bank, gen_count, disp_valid, ram_we, ram_addr);
        end
        tick();
        reset = 1'b0;
        exp_gen = 0;
        exp_bank = 1'b0;
        base = n_starts;
        pulse_step();
        wait_start(20, "coal");
        repeat (5) tick();
        pulse_step();
        repeat (9) tick();
        pulse_step();
        repeat (400) tick();
        exp_gen += 2;
        n_checks++;
        if (n_starts - base != 2 || gen_count !== 16'(exp_gen) || bank !== exp_bank || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL step_coalesce: starts=%0d gen=%0d bank=%b busy=%b, required starts=2 gen=%0d bank=%b busy=0",
                     n_starts - base, gen_count, bank, busy, exp_gen, exp_bank);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_edit_disp();
        test_eval_arb();
        test_run_period();
        test_run_random();
        test_step_with_run();
        test_watchdog();
        test_reset_mid_eval();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
